// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-stage register.
package pipe_pkg;

   // addi x0,x0,0 -- the canonical RV32I bubble
   localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

   // Occupancy FSM encoding
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Number of entries held in a given occupancy state
   function automatic logic [1:0] state_count(input logic [1:0] st);
      case (st)
         ST_ONE:  state_count = 2'd1;
         ST_TWO:  state_count = 2'd2;
         default: state_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry: valid flag plus ctrl/instr/data payload.
// A clear turns the entry into a bubble (ctrl=0, instr=NOP) but keeps data.
module pipe_entry_reg #(
   parameter int                 CTRL_W    = 8,
   parameter int                 INSTR_W   = 32,
   parameter int                 DATA_W    = 192,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               load,
   input  logic               clr,
   input  logic [CTRL_W-1:0]  d_ctrl,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [DATA_W-1:0]  d_data,
   output logic               q_vld,
   output logic [CTRL_W-1:0]  q_ctrl,
   output logic [INSTR_W-1:0] q_instr,
   output logic [DATA_W-1:0]  q_data
);

   logic               vld_reg;
   logic [CTRL_W-1:0]  ctrl_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic [DATA_W-1:0]  data_reg;

   // Load a new valid entry, or collapse to a bubble; load wins over clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_reg   <= 1'b0;
         ctrl_reg  <= '0;
         instr_reg <= NOP_INSTR;
         data_reg  <= '0;
      end else if (load) begin
         vld_reg   <= 1'b1;
         ctrl_reg  <= d_ctrl;
         instr_reg <= d_instr;
         data_reg  <= d_data;
      end else if (clr) begin
         vld_reg   <= 1'b0;
         ctrl_reg  <= '0;
         instr_reg <= NOP_INSTR;
      end
   end

   assign q_vld   = vld_reg;
   assign q_ctrl  = ctrl_reg;
   assign q_instr = instr_reg;
   assign q_data  = data_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and
// bubble injection. SKID=1 gives a two-entry skid buffer with registered o_rdy.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                 CTRL_W    = 8,
   parameter int                 DATA_W    = 192,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV_NOP_INSTR),
   parameter bit                 SKID      = 1'b1,
   parameter int                 CNT_W     = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_vld,
   output logic               o_rdy,
   input  logic [CTRL_W-1:0]  i_ctrl,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [DATA_W-1:0]  i_data,
   output logic               o_vld,
   input  logic               i_rdy,
   output logic [CTRL_W-1:0]  o_ctrl,
   output logic [INSTR_W-1:0] o_instr,
   output logic [DATA_W-1:0]  o_data,
   output logic [1:0]         o_count,
   output logic [CNT_W-1:0]   o_stall_cnt
);

   logic             head_vld;
   logic             skid_vld;
   logic             acc;
   logic             pop;
   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   // Input taken during a flush is dropped, so it never counts as accepted
   assign acc   = i_vld & o_rdy & ~i_flush;
   assign pop   = head_vld & i_rdy;
   assign o_vld = head_vld;

   generate
      if (SKID) begin : g_skid
         logic               head_load, head_clr, head_from_skid;
         logic               skid_load, skid_clr;
         logic [CTRL_W-1:0]  skid_ctrl;
         logic [INSTR_W-1:0] skid_instr;
         logic [DATA_W-1:0]  skid_data;

         // o_rdy depends only on the registered skid valid flag
         assign o_rdy          = ~skid_vld;
         assign head_from_skid = pop & skid_vld & ~i_flush;
         assign head_load      = head_from_skid | (acc & (~head_vld | pop));
         assign head_clr       = i_flush | pop;
         assign skid_load      = acc & head_vld & ~pop;
         assign skid_clr       = i_flush | head_from_skid;

         pipe_entry_reg #(
            .CTRL_W(CTRL_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)
         ) u_head (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .load    (head_load),
            .clr     (head_clr),
            .d_ctrl  (head_from_skid ? skid_ctrl  : i_ctrl),
            .d_instr (head_from_skid ? skid_instr : i_instr),
            .d_data  (head_from_skid ? skid_data  : i_data),
            .q_vld   (head_vld),
            .q_ctrl  (o_ctrl),
            .q_instr (o_instr),
            .q_data  (o_data)
         );

         pipe_entry_reg #(
            .CTRL_W(CTRL_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)
         ) u_skid (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .load    (skid_load),
            .clr     (skid_clr),
            .d_ctrl  (i_ctrl),
            .d_instr (i_instr),
            .d_data  (i_data),
            .q_vld   (skid_vld),
            .q_ctrl  (skid_ctrl),
            .q_instr (skid_instr),
            .q_data  (skid_data)
         );
      end else begin : g_single
         assign skid_vld = 1'b0;
         // Combinational ready: a pop this cycle frees the slot for a new entry
         assign o_rdy    = ~head_vld | i_rdy;

         pipe_entry_reg #(
            .CTRL_W(CTRL_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)
         ) u_head (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .load    (acc),
            .clr     (i_flush | pop),
            .d_ctrl  (i_ctrl),
            .d_instr (i_instr),
            .d_data  (i_data),
            .q_vld   (head_vld),
            .q_ctrl  (o_ctrl),
            .q_instr (o_instr),
            .q_data  (o_data)
         );
      end
   endgenerate

   // Occupancy FSM; flush always empties the stage
   always_comb begin
      state_next = state_reg;
      if (i_flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: if (acc) state_next = ST_ONE;
            ST_ONE: begin
               if (acc & ~pop)      state_next = ST_TWO;
               else if (pop & ~acc) state_next = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
         endcase
      end
   end

   // Occupancy state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_reg <= ST_EMPTY;
      else       state_reg <= state_next;
   end

   assign o_count = state_count(state_reg);

   // Saturating count of downstream-stalled cycles; flush does not clear it
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_reg <= '0;
      end else if (head_vld & ~i_rdy & ~(&stall_cnt_reg)) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: a SKID=1 stage (4-bit stall counter) and a SKID=0
// stage driven by the same stimulus, each compared to a queue model.
module tb_pipe_stage_elastic;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [7:0]  c;
      logic [31:0] i;
      logic [31:0] d;
   } ent_t;

   logic        i_clk = 1'b0;
   logic        i_rst, i_flush, i_vld, i_rdy;
   logic [7:0]  i_ctrl;
   logic [31:0] i_instr, i_data;

   logic        oa_rdy, oa_vld, ob_rdy, ob_vld;
   logic [7:0]  oa_ctrl, ob_ctrl;
   logic [31:0] oa_instr, oa_data, ob_instr, ob_data;
   logic [1:0]  oa_count, ob_count;
   logic [3:0]  oa_stall;
   logic [15:0] ob_stall;

   int checks = 0;
   int errors = 0;

   // Reference models: FIFO contents, last head data, stall counter
   ent_t        qa[$];
   ent_t        qb[$];
   logic [31:0] lda, ldb;
   int          sa, sb;

   always #5 i_clk = ~i_clk;

   pipe_stage_elastic #(
      .CTRL_W(8), .DATA_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .SKID(1'b1), .CNT_W(4)
   ) dut_a (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(oa_rdy),
      .i_ctrl(i_ctrl), .i_instr(i_instr), .i_data(i_data), .o_vld(oa_vld), .i_rdy(i_rdy),
      .o_ctrl(oa_ctrl), .o_instr(oa_instr), .o_data(oa_data), .o_count(oa_count),
      .o_stall_cnt(oa_stall)
   );

   pipe_stage_elastic #(
      .CTRL_W(8), .DATA_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .SKID(1'b0), .CNT_W(16)
   ) dut_b (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(ob_rdy),
      .i_ctrl(i_ctrl), .i_instr(i_instr), .i_data(i_data), .o_vld(ob_vld), .i_rdy(i_rdy),
      .o_ctrl(ob_ctrl), .o_instr(ob_instr), .o_data(ob_data), .o_count(ob_count),
      .o_stall_cnt(ob_stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      qa.delete();
      qb.delete();
      lda = '0;
      ldb = '0;
      sa  = 0;
      sb  = 0;
   endtask

   // Compare every output of both stages with the models' current state
   task automatic check_all(input string ph);
      logic        va, vb;
      va = (qa.size() > 0);
      vb = (qb.size() > 0);
      chk({ph, " a.vld"},   64'(oa_vld),   64'(va));
      chk({ph, " a.rdy"},   64'(oa_rdy),   64'(qa.size() < 2));
      chk({ph, " a.ctrl"},  64'(oa_ctrl),  va ? 64'(qa[0].c) : 64'(0));
      chk({ph, " a.instr"}, 64'(oa_instr), va ? 64'(qa[0].i) : 64'(NOP));
      chk({ph, " a.data"},  64'(oa_data),  va ? 64'(qa[0].d) : 64'(lda));
      chk({ph, " a.count"}, 64'(oa_count), 64'(qa.size()));
      chk({ph, " a.stall"}, 64'(oa_stall), 64'(sa));
      chk({ph, " b.vld"},   64'(ob_vld),   64'(vb));
      chk({ph, " b.rdy"},   64'(ob_rdy),   64'(!vb || i_rdy));
      chk({ph, " b.ctrl"},  64'(ob_ctrl),  vb ? 64'(qb[0].c) : 64'(0));
      chk({ph, " b.instr"}, 64'(ob_instr), vb ? 64'(qb[0].i) : 64'(NOP));
      chk({ph, " b.data"},  64'(ob_data),  vb ? 64'(qb[0].d) : 64'(ldb));
      chk({ph, " b.count"}, 64'(ob_count), 64'(qb.size()));
      chk({ph, " b.stall"}, 64'(ob_stall), 64'(sb));
   endtask

   // One clock cycle: drive inputs, check at negedge, advance models for the edge
   task automatic step(input string ph, input logic fl, input logic v, input logic [7:0] c,
                       input logic [31:0] ins, input logic [31:0] d, input logic r);
      logic ra, rb;
      ent_t e;
      i_flush = fl; i_vld = v; i_ctrl = c; i_instr = ins; i_data = d; i_rdy = r;
      @(negedge i_clk);
      check_all(ph);
      $display("%s: flush=%0b vld=%0b instr=%h rdy=%0b | a: vld=%0b instr=%h cnt=%0d stall=%0d | b: vld=%0b instr=%h stall=%0d",
               ph, fl, v, ins, r, oa_vld, oa_instr, oa_count, oa_stall, ob_vld, ob_instr, ob_stall);
      e  = '{c: c, i: ins, d: d};
      ra = (qa.size() < 2);
      rb = (qb.size() == 0) || r;
      if (qa.size() > 0 && !r && sa != 15) sa++;
      if (qb.size() > 0 && !r && sb != 65535) sb++;
      if (fl) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() > 0 && r) void'(qa.pop_front());
         if (qb.size() > 0 && r) void'(qb.pop_front());
         if (v && ra) qa.push_back(e);
         if (v && rb) qb.push_back(e);
      end
      if (qa.size() > 0) lda = qa[0].d;
      if (qb.size() > 0) ldb = qb[0].d;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      // Reset state
      i_rst = 1'b1; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
      i_ctrl = '0; i_instr = '0; i_data = '0;
      model_reset();
      @(negedge i_clk);
      check_all("reset");
      @(posedge i_clk);
      #1 i_rst = 1'b0;

      // Back-to-back stream with downstream always ready
      for (int k = 1; k <= 4; k++)
         step("stream", 1'b0, 1'b1, 8'(8'hA0 + k), 32'(k), $urandom, 1'b1);
      step("drain", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
      step("drain", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);

      // Backpressure: two pushes while stalled, then release
      step("bp_push", 1'b0, 1'b1, 8'h11, 32'hAAAA_0001, 32'h1111_1111, 1'b0);
      step("bp_push", 1'b0, 1'b1, 8'h22, 32'hBBBB_0002, 32'h2222_2222, 1'b0);
      for (int k = 0; k < 3; k++)
         step("bp_hold", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++)
         step("bp_rel", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);

      // Flush with a full stage and a new entry C offered in the same cycle
      step("fl_push", 1'b0, 1'b1, 8'h33, 32'hAAAA_0003, 32'h3333_3333, 1'b0);
      step("fl_push", 1'b0, 1'b1, 8'h44, 32'hBBBB_0004, 32'h4444_4444, 1'b0);
      step("flush",   1'b1, 1'b1, 8'h55, 32'hCCCC_0005, 32'h5555_5555, 1'b1);
      step("post_fl", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
      step("post_fl", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);

      // Stall counter saturation: 20 stalled cycles with a held entry
      step("sat_push", 1'b0, 1'b1, 8'h66, 32'h0000_0666, 32'h6666_6666, 1'b0);
      for (int k = 0; k < 20; k++)
         step("sat", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
      step("sat_fl", 1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);

      // Randomised traffic
      for (int k = 0; k < 300; k++)
         step("rand", ($urandom_range(15) == 0), 1'($urandom_range(1)), 8'($urandom),
              $urandom, $urandom, ($urandom_range(2) != 0));

      // Asynchronous reset asserted mid-cycle with entries held
      step("pre_rst", 1'b0, 1'b1, 8'h77, 32'h0000_0777, 32'h7777_7777, 1'b0);
      step("pre_rst", 1'b0, 1'b1, 8'h88, 32'h0000_0888, 32'h8888_8888, 1'b0);
      #2 i_rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      for (int k = 0; k < 6; k++)
         step("after_rst", 1'b0, 1'b1, 8'($urandom), 32'(k + 100), $urandom, 1'($urandom_range(1)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
